// File: rtl/lzc_pkg.sv
// Shared types and helpers for the sequential leading-zero counter.
package lzc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    function automatic int cnt_w(input int x);
        return $clog2(x + 1);
    endfunction

endpackage

// File: rtl/lzc_seq_ctrl_if.sv
// Operand request and result handshake bundle for lzc_seq_ctrl.
interface lzc_seq_ctrl_if
    import lzc_pkg::*;
#(
    parameter int DATA_W = 32
);
    localparam int CW = cnt_w(DATA_W);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     out_count;
    logic              out_nonzero;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_count,
        input  out_nonzero
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_count,
        output out_nonzero
    );

endinterface

// File: rtl/lzc_chunk.sv
// Combinational leading-zero count of one chunk, scanned from its MSB.
module lzc_chunk
    import lzc_pkg::*;
#(
    parameter int CHUNK_W = 8,
    localparam int CCW = cnt_w(CHUNK_W)
) (
    input  logic [CHUNK_W-1:0] chunk,
    output logic [CCW-1:0]     count,
    output logic               nonzero
);

    always_comb begin
        count   = '0;
        nonzero = 1'b0;
        for (int i = CHUNK_W - 1; i >= 0; i--) begin
            if (!nonzero) begin
                if (chunk[i]) begin
                    nonzero = 1'b1;
                end else begin
                    count = count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lzc_seq_ctrl.sv
// Sequential leading-zero counter: scans one chunk per cycle from the MSB.
module lzc_seq_ctrl
    import lzc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CHUNK_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    lzc_seq_ctrl_if.slave bus,
    output logic         busy
);

    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int CW     = cnt_w(DATA_W);
    localparam int CCW    = cnt_w(CHUNK_W);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

    generate
        if ((DATA_W % CHUNK_W) != 0 || NCHUNK < 2) begin : g_bad_params
            $error("lzc_seq_ctrl: DATA_W must be a multiple of CHUNK_W, >= 2 chunks");
        end
    endgenerate

    state_t            state;
    logic [DATA_W-1:0] sh;
    logic [CW-1:0]     acc;
    logic [IDX_W-1:0]  idx;
    logic              nz;

    logic [CCW-1:0]    ccnt;
    logic              cnz;

    lzc_chunk #(
        .CHUNK_W (CHUNK_W)
    ) u_chunk (
        .chunk   (sh[DATA_W-1 -: CHUNK_W]),
        .count   (ccnt),
        .nonzero (cnz)
    );

    // DONE spends one cycle registering the result before raising out_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            sh              <= '0;
            acc             <= '0;
            idx             <= '0;
            nz              <= 1'b0;
            busy            <= 1'b0;
            bus.in_ready    <= 1'b1;
            bus.out_valid   <= 1'b0;
            bus.out_count   <= '0;
            bus.out_nonzero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sh           <= bus.in_data;
                        acc          <= '0;
                        idx          <= '0;
                        state        <= SCAN;
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                SCAN: begin
                    if (cnz) begin
                        acc   <= acc + CW'(ccnt);
                        nz    <= 1'b1;
                        state <= DONE;
                    end else begin
                        acc <= acc + CW'(CHUNK_W);
                        if (idx == LAST) begin
                            nz    <= 1'b0;
                            state <= DONE;
                        end else begin
                            sh  <= sh << CHUNK_W;
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!bus.out_valid) begin
                        bus.out_valid   <= 1'b1;
                        bus.out_count   <= acc;
                        bus.out_nonzero <= nz;
                    end else if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lzc_seq_ctrl.sv
// Self-checking bench for lzc_seq_ctrl with DATA_W=32, CHUNK_W=8.
module tb_lzc_seq_ctrl;

    localparam int DW     = 32;
    localparam int CWD    = 8;
    localparam int NCHUNK = DW / CWD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    int n_asrt = 0;
    int n_fail = 0;

    lzc_seq_ctrl_if #(.DATA_W(DW)) bus ();

    lzc_seq_ctrl #(
        .DATA_W  (DW),
        .CHUNK_W (CWD)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          hold;
        int          cnt;
        bit          nz;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_asrt++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int ref_clz(input logic [31:0] x);
        for (int i = 31; i >= 0; i--) begin
            if (x[i]) return 31 - i;
        end
        return 32;
    endfunction

    function automatic int ref_lat(input logic [31:0] x);
        if (x == 0) return NCHUNK + 1;
        return ref_clz(x) / CWD + 2;
    endfunction

    // Called with time just after a rising edge.
    task automatic run_op(input string name, input logic [31:0] d,
                          input int hold, input int exp_cnt,
                          input bit exp_nz, input int exp_lat);
        int lat;
        logic [5:0] cnt0;
        logic nz0;
        lat = 0;
        chk({name, " in_ready idle"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        for (int n = 1; n <= 20; n++) begin
            if (bus.out_valid) begin
                lat = n - 1;
                break;
            end
            @(posedge clk);
            #1;
            bus.in_valid = $urandom_range(0, 1);
            bus.in_data  = $urandom;
            if (bus.out_valid) begin
                lat = n;
                break;
            end
        end
        bus.in_valid = 1'b0;
        if (lat == 0) begin
            chk({name, " timeout"}, 64'd0, 64'd1);
            return;
        end
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        chk({name, " count"}, 64'(bus.out_count), 64'(exp_cnt));
        chk({name, " nonzero"}, 64'(bus.out_nonzero), 64'(exp_nz));
        chk({name, " in_ready busy"}, 64'(bus.in_ready), 64'd0);
        cnt0 = bus.out_count;
        nz0  = bus.out_nonzero;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            chk({name, " hold valid"}, 64'(bus.out_valid), 64'd1);
            chk({name, " hold stable"},
                64'({bus.out_count, bus.out_nonzero}), 64'({cnt0, nz0}));
            chk({name, " hold in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({name, " post in_ready"}, 64'(bus.in_ready), 64'd1);
        chk({name, " post valid"}, 64'(bus.out_valid), 64'd0);
        chk({name, " post busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [31:0] d;
        int h;
        bit saw;

        vecs[0] = '{32'h8000_0000, 0, 0, 1'b1, 2};
        vecs[1] = '{32'h0000_2800, 0, 18, 1'b1, 4};
        vecs[2] = '{32'h0000_0000, 0, 32, 1'b0, 5};
        vecs[3] = '{32'h0000_0001, 0, 31, 1'b1, 5};
        vecs[4] = '{32'h00F0_0000, 0, 8, 1'b1, 3};
        vecs[5] = '{32'hFFFF_FFFF, 3, 0, 1'b1, 2};
        vecs[6] = '{32'h0000_0100, 2, 23, 1'b1, 4};
        vecs[7] = '{32'h0100_0000, 1, 7, 1'b1, 2};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset count", 64'(bus.out_count), 64'd0);
        chk("reset nonzero", 64'(bus.out_nonzero), 64'd0);

        // Reset wins over a simultaneous request
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst = 1'b0;
        chk("rst prio busy", 64'(busy), 64'd0);
        chk("rst prio in_ready", 64'(bus.in_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].data, vecs[i].hold,
                   vecs[i].cnt, vecs[i].nz, vecs[i].lat);
        end

        // Abort in the second SCAN cycle
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_0001;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort in_ready", 64'(bus.in_ready), 64'd1);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort count", 64'(bus.out_count), 64'd0);
        saw = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (bus.out_valid) saw = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b0;
        chk("abort no result", 64'(saw), 64'd0);
        run_op("after abort", 32'h00F0_0000, 0, 8, 1'b1, 3);

        for (int i = 0; i < 150; i++) begin
            d = $urandom >> $urandom_range(0, 32);
            h = $urandom_range(0, 2);
            run_op($sformatf("rnd%0d", i), d, h, ref_clz(d), d != 0,
                   ref_lat(d));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/lzc_seq_ctrl.md
LZC_SEQ_CTRL -- requirements
Module: lzc_seq_ctrl

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, giving the operand width in bits.
REQ-002 The module SHALL have parameter CHUNK_W, default 8, giving the bits examined per scan cycle.
REQ-003 DATA_W SHALL be an integer multiple of CHUNK_W with NCHUNK = DATA_W/CHUNK_W >= 2, checked by elaboration-time assertion.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port in_valid, input, 1 bit: request operand present.
REQ-007 Port in_ready, output, 1 bit: block accepts an operand.
REQ-008 Port in_data, input, DATA_W bits: operand to scan.
REQ-009 Port out_valid, output, 1 bit: result present.
REQ-010 Port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 Port out_count, output, $clog2(DATA_W+1) bits: leading-zero count from the MSB.
REQ-012 Port out_nonzero, output, 1 bit: operand had at least one set bit.
REQ-013 Port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, SCAN and DONE.
REQ-015 In IDLE: in_ready=1 and out_valid=0; on in_valid&in_ready, capture in_data into a shift register, clear the accumulator and chunk index, and go to SCAN.
REQ-016 In SCAN: each cycle, present the top CHUNK_W bits of the shift register to the chunk counter.
REQ-017 SCAN, chunk nonzero: acc += chunk count, set nonzero flag, go to DONE.
REQ-018 SCAN, chunk zero, index < NCHUNK-1: acc += CHUNK_W, shift left by CHUNK_W, index++, stay in SCAN.
REQ-019 SCAN, chunk zero, index = NCHUNK-1: acc += CHUNK_W, clear nonzero flag, go to DONE.
REQ-020 In DONE: out_valid=1; out_count=acc and out_nonzero=flag; both SHALL be held stable until out_valid&out_ready, then go to IDLE.
REQ-021 in_ready SHALL be 0 in SCAN and DONE; in_valid and in_data SHALL be ignored outside an IDLE handshake.
REQ-022 Latency: if j is the index of the first nonzero chunk counted from the MSB (j=0..NCHUNK-1), out_valid SHALL rise j+2 cycles after the accepting edge.
REQ-023 Latency for an all-zero operand SHALL be NCHUNK+1 cycles.
REQ-024 An all-zero operand SHALL give out_count=DATA_W (full width, no wrap) and out_nonzero=0.
REQ-025 The accumulator SHALL be $clog2(DATA_W+1) bits wide and SHALL never overflow.
REQ-026 in_ready SHALL return to 1 the cycle after the output handshake; there is no overlap of operations.

Reset
REQ-027 While rst is high at a rising edge, the next state SHALL be IDLE with out_valid=0, busy=0, in_ready=1, out_count=0, out_nonzero=0, accumulator=0 and index=0.
REQ-028 rst asserted in SCAN or DONE SHALL discard the operation without emitting a result.
REQ-029 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-030 Package lzc_pkg SHALL hold the state_t enum (IDLE, SCAN, DONE).
REQ-031 lzc_pkg SHALL hold a count-width function for clog2(x+1).
REQ-032 Sub-module lzc_chunk SHALL be combinational, CHUNK_W-bit input, $clog2(CHUNK_W+1)-bit count, 1-bit nonzero.
REQ-033 lzc_chunk SHALL be instantiated once and time-shared across chunks by the FSM.

Verification (DATA_W=32, CHUNK_W=8)
REQ-034 in_data=0x8000_0000, out_ready=1 -> out_count=0, out_nonzero=1, out_valid 2 cycles after accept.
REQ-035 in_data=0x0000_2800 -> out_count=18, out_nonzero=1, out_valid 4 cycles after accept.
REQ-036 in_data=0x0000_0000 -> out_count=32, out_nonzero=0, out_valid 5 cycles after accept; in_data=0x0000_0001 -> out_count=31, 5 cycles.
REQ-037 Result ready, out_ready=0 for 3 cycles -> outputs stable and in_ready=0 throughout; in_ready=1 the cycle after out_ready rises.
REQ-038 rst pulsed in the second SCAN cycle of 0x0000_0001 -> next cycle IDLE, in_ready=1, out_valid never asserted; the following operand 0x00F0_0000 returns out_count=8.
